// File: rtl/byang_byte_bridge.sv
// ---------------------------------------------------------------------------
// byang_byte_bridge
//
// Byte-serial front end for the secp256k1 modular inverter.
//
// Input path : 32 host bytes (MSB first) are collected into one operand,
//              reduced once mod P and presented to the inverter over a
//              valid/ready port. The next frame may stream in while the
//              current operand waits; only its final byte stalls.
// Output path: the inverter's 256-bit result is captured and serialized
//              back to the host MSB first, one byte per accepted cycle.
//
// Ports
//   clk, rst                      clock (rising edge), sync active-high reset
//   in_valid/in_ready/in_byte     host operand byte stream
//   inv_valid/inv_ready/inv_a     reduced operand toward the inverter
//   res_valid/res_ready/res_data  result from the inverter
//   out_valid/out_ready/out_byte  host result byte stream
//   red_pulse                     one-cycle pulse: last operand was >= P
// ---------------------------------------------------------------------------
`ifndef PRIME_BITS
`define PRIME_BITS 256
`endif

module byang_byte_bridge #(
   parameter int PRIME_BITS = `PRIME_BITS,
   parameter int NBYTES     = PRIME_BITS / 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [7:0]            in_byte,
   output logic                  inv_valid,
   input  logic                  inv_ready,
   output logic [PRIME_BITS-1:0] inv_a,
   input  logic                  res_valid,
   output logic                  res_ready,
   input  logic [PRIME_BITS-1:0] res_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [7:0]            out_byte,
   output logic                  red_pulse
);

   localparam logic [255:0] SECP_P =
      256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;
   localparam logic [PRIME_BITS-1:0] P = PRIME_BITS'(SECP_P);

   localparam int CW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam logic [CW-1:0] LAST_IDX = CW'(NBYTES - 1);

   // ------------------------------------------------------------------
   // Input path
   // ------------------------------------------------------------------
   // sr only needs to hold the bytes that precede the final one; the final
   // byte is taken straight from in_byte when the frame completes.
   logic [PRIME_BITS-9:0] sr_reg;
   logic [CW-1:0]         in_cnt_reg;
   logic [PRIME_BITS-1:0] iss_reg;
   logic                  iss_v_reg;
   logic                  red_pulse_reg;

   logic                  in_fire;
   logic                  in_last;
   logic                  frame_done;
   logic                  iss_take;
   logic [PRIME_BITS-1:0] full;
   logic                  need_red;
   logic [PRIME_BITS-1:0] reduced;

   assign in_last    = (in_cnt_reg == LAST_IDX);
   // The final byte of a frame waits until the pending operand has gone.
   assign in_ready   = ~(iss_v_reg & in_last);
   assign in_fire    = in_valid & in_ready;
   assign frame_done = in_fire & in_last;
   assign iss_take   = iss_v_reg & inv_ready;

   assign full     = {sr_reg, in_byte};
   // A single conditional subtraction is enough: 2^256 < 2P.
   assign need_red = (full >= P);
   assign reduced  = need_red ? (full - P) : full;

   always_ff @(posedge clk) begin
      if (rst) begin
         sr_reg        <= '0;
         in_cnt_reg    <= '0;
         iss_reg       <= '0;
         iss_v_reg     <= 1'b0;
         red_pulse_reg <= 1'b0;
      end else begin
         if (in_fire) begin
            sr_reg     <= full[PRIME_BITS-9:0];
            in_cnt_reg <= in_last ? '0 : in_cnt_reg + CW'(1);
         end
         if (frame_done) begin
            iss_reg <= reduced;
         end
         // A new frame landing takes priority over consumption of the old one.
         if (frame_done) begin
            iss_v_reg <= 1'b1;
         end else if (iss_take) begin
            iss_v_reg <= 1'b0;
         end
         red_pulse_reg <= frame_done & need_red;
      end
   end

   assign inv_valid = iss_v_reg;
   assign inv_a     = iss_reg;
   assign red_pulse = red_pulse_reg;

   // ------------------------------------------------------------------
   // Output path
   // ------------------------------------------------------------------
   typedef enum logic {OIDLE, OSEND} ostate_t;

   ostate_t               ostate_reg;
   ostate_t               ostate_next;
   logic [PRIME_BITS-1:0] osr_reg;
   logic [CW-1:0]         out_cnt_reg;
   logic                  osr_load;
   logic                  osr_shift;
   logic                  out_last;

   assign out_last = (out_cnt_reg == LAST_IDX);

   always_ff @(posedge clk) begin
      if (rst) begin
         ostate_reg <= OIDLE;
      end else begin
         ostate_reg <= ostate_next;
      end
   end

   // res_ready depends on state only, never on res_valid.
   always_comb begin
      ostate_next = ostate_reg;
      res_ready   = 1'b0;
      out_valid   = 1'b0;
      osr_load    = 1'b0;
      osr_shift   = 1'b0;
      case (ostate_reg)
         OIDLE: begin
            res_ready = 1'b1;
            if (res_valid) begin
               osr_load    = 1'b1;
               ostate_next = OSEND;
            end
         end
         OSEND: begin
            out_valid = 1'b1;
            if (out_ready) begin
               osr_shift = 1'b1;
               if (out_last) begin
                  ostate_next = OIDLE;
               end
            end
         end
         default: begin
            ostate_next = OIDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         osr_reg     <= '0;
         out_cnt_reg <= '0;
      end else if (osr_load) begin
         osr_reg     <= res_data;
         out_cnt_reg <= '0;
      end else if (osr_shift) begin
         osr_reg     <= {osr_reg[PRIME_BITS-9:0], 8'h00};
         out_cnt_reg <= out_last ? '0 : out_cnt_reg + CW'(1);
      end
   end

   assign out_byte = osr_reg[PRIME_BITS-1 -: 8];

endmodule
